// File: rtl/vedic_pkg.sv
// Shared widths and FSM encoding for the sequential vedic multiplier.
package vedic_pkg;

  localparam int unsigned OP_W   = 16;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned PROD_W = 32;
  localparam int unsigned PP_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/vedic_4bit.sv
// 4x4 unsigned vedic multiplier built from four 2x2 urdhva blocks; purely combinational.
module vedic_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
    logic [3:0] r;
    r = {2'b00, x & {2{y[0]}}} + {1'b0, x & {2{y[1]}}, 1'b0};
    return r;
  endfunction

  logic [3:0] q0, q1, q2, q3;

  always_comb begin
    q0 = mul2(a[1:0], b[1:0]);
    q1 = mul2(a[3:2], b[1:0]);
    q2 = mul2(a[1:0], b[3:2]);
    q3 = mul2(a[3:2], b[3:2]);
    p  = {4'b0000, q0} + {2'b00, q1, 2'b00} + {2'b00, q2, 2'b00} + {q3, 4'b0000};
  end

endmodule

// File: rtl/vedic_seq_mult16.sv
// Iterative 16x16 unsigned multiplier: one vedic_4bit core walks all 16 nibble pairs and
// shift-accumulates the partial products.
module vedic_seq_mult16
  import vedic_pkg::*;
#(
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic              busy
);

  state_e              state_q;
  logic [OP_W-1:0]     a_q, b_q;
  logic [PROD_W-1:0]   acc_q, product_q;
  logic [3:0]          idx_q;

  logic [1:0]          i_sel, j_sel;
  logic [NIB_W-1:0]    a_nib, b_nib;
  logic [PP_W-1:0]     pp;
  logic [4:0]          shamt;
  logic [PROD_W-1:0]   term, acc_sum;

  assign i_sel = idx_q[3:2];
  assign j_sel = idx_q[1:0];
  assign a_nib = a_q[{i_sel, 2'b00} +: NIB_W];
  assign b_nib = b_q[{j_sel, 2'b00} +: NIB_W];

  vedic_4bit u_core (
    .a (a_nib),
    .b (b_nib),
    .p (pp)
  );

  // Nibble weight is 4*(i+j); max shift 24 keeps every term inside 32 bits.
  assign shamt   = {({1'b0, i_sel} + {1'b0, j_sel}), 2'b00};
  assign term    = {{(PROD_W - PP_W){1'b0}}, pp} << shamt;
  assign acc_sum = acc_q + term;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      product_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            acc_q <= '0;
            idx_q <= '0;
            if (ZERO_SKIP && (a == '0 || b == '0)) begin
              product_q <= '0;
              state_q   <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          acc_q <= acc_sum;
          idx_q <= idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            product_q <= acc_sum;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC) || (state_q == DONE);
  assign product   = product_q;

endmodule

// File: tb/tb_vedic_seq_mult16.sv
// Self-checking bench: two instances (zero-skip on/off) share stimulus and are compared
// against a plain a*b reference with latency and handshake checks.
module tb_vedic_seq_mult16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] a, b;
  logic        out_ready;
  logic        in_ready0, out_valid0, busy0;
  logic        in_ready1, out_valid1, busy1;
  logic [31:0] product0, product1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  vedic_seq_mult16 #(.ZERO_SKIP(1'b1)) dut_skip (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .a         (a),
    .b         (b),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .product   (product0),
    .busy      (busy0)
  );

  vedic_seq_mult16 #(.ZERO_SKIP(1'b0)) dut_noskip (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .a         (a),
    .b         (b),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .product   (product1),
    .busy      (busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    return {16'h0, x} * {16'h0, y};
  endfunction

  // Called at the negedge right after the accept edge. Waits for both results, checks
  // latency (edges after the accept edge), the product, and that the block stayed busy.
  task automatic collect(input logic [15:0] x, input logic [15:0] y);
    int e = 0;
    int lat0 = -1;
    int lat1 = -1;
    bit busy_ok = 1'b1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    while ((lat0 < 0 || lat1 < 0) && e < 40) begin
      if (out_valid0 && lat0 < 0) lat0 = e;
      if (out_valid1 && lat1 < 0) lat1 = e;
      if (!busy1 || in_ready1 || (lat0 < 0 && (!busy0 || in_ready0))) busy_ok = 1'b0;
      @(negedge clk);
      e++;
    end
    if (out_valid0 && lat0 < 0) lat0 = e;
    if (out_valid1 && lat1 < 0) lat1 = e;
    chk("lat_skip", 32'(lat0), (x == 16'h0 || y == 16'h0) ? 32'd0 : 32'd16);
    chk("lat_noskip", 32'(lat1), 32'd16);
    chk("prod_skip", product0, ref_mul(x, y));
    chk("prod_noskip", product1, ref_mul(x, y));
    chk("busy_during_op", 32'(busy_ok), 32'd1);
  endtask

  task automatic submit(input logic [15:0] x, input logic [15:0] y);
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic handshake(input logic [31:0] exp);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("hs_idle", {in_ready0, out_valid0, in_ready1, out_valid1}, 32'b1010);
    chk("hs_prod_held", product0, exp);
  endtask

  initial begin
    logic [15:0] x, y;
    bit held;
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b0;
    a = 16'h0003;
    b = 16'h0005;

    // Reset with in_valid high must not accept anything.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_flags", {in_ready0, out_valid0, busy0, in_ready1, out_valid1, busy1}, 32'b100100);
    chk("rst_prod", product0 | product1, 32'h0);
    @(negedge clk);
    chk("rst_no_accept", {busy0, busy1}, 32'b00);

    // Basic, max, and squares sweep.
    submit(16'h0003, 16'h0005);
    collect(16'h0003, 16'h0005);
    chk("basic_prod", product0, 32'h0000000F);
    handshake(32'h0000000F);
    submit(16'hFFFF, 16'hFFFF);
    collect(16'hFFFF, 16'hFFFF);
    chk("max_prod", product1, 32'hFFFE0001);
    handshake(32'hFFFE0001);
    for (int n = 0; n < 16; n++) begin
      submit(16'(n), 16'(n));
      collect(16'(n), 16'(n));
      handshake(32'(n * n));
    end

    // Zero skip: instance 0 finishes immediately and holds while instance 1 computes.
    submit(16'h0000, 16'h1234);
    chk("zs_done_now", {out_valid0, busy1, out_valid1}, 32'b110);
    collect(16'h0000, 16'h1234);
    handshake(32'h0);

    // Backpressure: DONE holds, new operands ignored until handshake.
    submit(16'hBEEF, 16'h1357);
    collect(16'hBEEF, 16'h1357);
    held = 1'b1;
    in_valid = 1'b1;
    a = 16'h00A5;
    b = 16'h0101;
    repeat (5) begin
      @(negedge clk);
      if (!out_valid0 || in_ready0 || product0 !== ref_mul(16'hBEEF, 16'h1357)) held = 1'b0;
    end
    chk("bp_held", 32'(held), 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle", {in_ready0, out_valid0, busy0}, 32'b100);
    @(posedge clk);
    @(negedge clk);
    chk("bp_accept", {in_ready0, busy0}, 32'b01);
    collect(16'h00A5, 16'h0101);
    handshake(ref_mul(16'h00A5, 16'h0101));

    // Abort mid-CALC with reset, then resubmit.
    submit(16'h1234, 16'h5678);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_flags", {in_ready0, out_valid0, busy0, in_ready1, out_valid1, busy1}, 32'b100100);
    chk("abort_prod", product0, 32'h0);
    held = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid0 || out_valid1) held = 1'b0;
    end
    chk("abort_no_valid", 32'(held), 32'd1);
    submit(16'h1234, 16'h5678);
    collect(16'h1234, 16'h5678);
    chk("abort_resubmit", product0, 32'h06260060);
    handshake(32'h06260060);

    // Random pairs, occasionally forcing a zero operand.
    for (int k = 0; k < 2500; k++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      if ($urandom_range(0, 31) == 0) x = 16'h0;
      if ($urandom_range(0, 31) == 0) y = 16'h0;
      submit(x, y);
      collect(x, y);
      handshake(ref_mul(x, y));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
